// File: rtl/uart_rx_pkg.sv
// ----------------------------------------------------------------------------
// Definitions : shared state encoding and width helper for the UART receiver
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package Definitions;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        PARITY    = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_e;

    // Smallest r with 2**r >= value.
    function automatic int CeilLog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_shift.sv
// ----------------------------------------------------------------------------
// shift_register_sipo : serial-in / parallel-out right-shift register
// Revision            : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module shift_register_sipo #(
    parameter int Word_Length = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   shift,
    input  logic                   serial_in,
    output logic [Word_Length-1:0] Data_Output
);

    logic [Word_Length-1:0] r_data;

    // New bits enter at the MSB so an LSB-first stream ends up LSB-aligned.
    generate
        if (Word_Length > 1) begin : g_multi
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data <= '0;
                end else if (shift) begin
                    r_data <= {serial_in, r_data[Word_Length-1:1]};
                end
            end
        end else begin : g_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data <= '0;
                end else if (shift) begin
                    r_data <= serial_in;
                end
            end
        end
    endgenerate

    assign Data_Output = r_data;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx : one-bit-per-clock UART receiver with even parity and framing check
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx
    import Definitions::*;
#(
    parameter int WORD_LENGHT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Rx_in,
    output logic [WORD_LENGHT-1:0] Rx_data,
    output logic                   Rx_valid,
    output logic                   Parity_error,
    output logic                   Frame_error,
    output logic                   Rx_busy
);

    localparam int CNT_W = CeilLog2(WORD_LENGHT + 1);
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(WORD_LENGHT - 1);

    rx_state_e              r_state;
    rx_state_e              w_next_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_perr;
    logic [WORD_LENGHT-1:0] r_rx_data;
    logic                   r_rx_valid;
    logic                   r_parity_error;
    logic                   r_frame_error;
    logic [WORD_LENGHT-1:0] w_shreg;
    logic                   w_shift;
    logic                   w_cnt_clr;
    logic                   w_cnt_inc;
    logic                   w_perr_load;
    logic                   w_frame_done;

    shift_register_sipo #(
        .Word_Length (WORD_LENGHT)
    ) u_sipo (
        .clk         (clk),
        .rst         (rst),
        .shift       (w_shift),
        .serial_in   (Rx_in),
        .Data_Output (w_shreg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_shift      = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_perr_load  = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (!Rx_in) begin
                    w_next_state = DATA;
                    w_cnt_clr    = 1'b1;
                end
            end
            DATA: begin
                w_shift = 1'b1;
                if (r_bit_cnt == c_LAST_BIT) begin
                    w_next_state = PARITY;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            PARITY: begin
                w_perr_load  = 1'b1;
                w_next_state = STOP;
            end
            STOP: begin
                w_frame_done = 1'b1;
                // A low stop bit must not be mistaken for the next start bit.
                w_next_state = Rx_in ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (Rx_in) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt      <= '0;
            r_perr         <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            if (w_cnt_clr) begin
                r_bit_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_perr_load) begin
                r_perr <= Rx_in ^ (^w_shreg);
            end
            r_rx_valid <= w_frame_done;
            if (w_frame_done) begin
                r_rx_data      <= w_shreg;
                r_parity_error <= r_perr;
                r_frame_error  <= ~Rx_in;
            end
        end
    end

    assign Rx_data      = r_rx_data;
    assign Rx_valid     = r_rx_valid;
    assign Parity_error = r_parity_error;
    assign Frame_error  = r_frame_error;
    assign Rx_busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx : scoreboard bench for uart_rx (WORD_LENGHT = 8)
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       Rx_in;
    logic [7:0] Rx_data;
    logic       Rx_valid;
    logic       Parity_error;
    logic       Frame_error;
    logic       Rx_busy;

    uart_rx #(
        .WORD_LENGHT (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Rx_in        (Rx_in),
        .Rx_data      (Rx_data),
        .Rx_valid     (Rx_valid),
        .Parity_error (Parity_error),
        .Frame_error  (Frame_error),
        .Rx_busy      (Rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_valid = 0;
    int   last_valid_cyc = 0;
    int   prev_valid_cyc = 0;
    int   start_cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every Rx_valid pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && Rx_valid === 1'b1) begin
            exp_t e;
            n_valid++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data %0h required no pulse", Rx_data);
            end else begin
                e = sbq.pop_front();
                check("rx_data", 32'(Rx_data), 32'(e.d));
                check("parity_error", 32'(Parity_error), 32'(e.pe));
                check("frame_error", 32'(Frame_error), 32'(e.fe));
            end
        end
    end

    task automatic send_bit(input logic b);
        Rx_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    // Frame: start, 8 data LSB-first, even parity (optionally inverted), stop.
    task automatic send_frame(input logic [7:0] d, input logic par_ok,
                              input logic stop, input bit expect_it);
        exp_t e;
        if (expect_it) begin
            e.d  = d;
            e.pe = ~par_ok;
            e.fe = ~stop;
            sbq.push_back(e);
        end
        send_bit(1'b0);
        start_cyc = cyc;
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par_ok ? (^d) : ~(^d));
        send_bit(stop);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [7:0] w;
        rst   = 1'b1;
        Rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", 32'(Rx_data), 32'h0);
        check("reset_valid", 32'(Rx_valid), 32'h0);
        check("reset_perr", 32'(Parity_error), 32'h0);
        check("reset_ferr", 32'(Frame_error), 32'h0);
        check("reset_busy", 32'(Rx_busy), 32'h0);
        rst = 1'b0;
        idle(3);

        // 0xA5: line 0,1,0,1,0,0,1,0,1,0,1
        n0 = n_valid;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        idle(4);
        check("a5_pulse_count", 32'(n_valid - n0), 32'd1);
        // Visible in the cycle after the stop-sample edge (edge 10 after start).
        check("a5_latency", 32'(last_valid_cyc - start_cyc), 32'd10);
        check("valid_deassert", 32'(Rx_valid), 32'h0);

        // Parity fault: 0x01 needs parity 1, send 0.
        send_frame(8'h01, 1'b0, 1'b1, 1'b1);
        idle(4);

        // Stop fault, then line low for 3 cycles.
        n0 = n_valid;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b0);
            check("wait_idle_busy", 32'(Rx_busy), 32'h1);
        end
        send_bit(1'b1);
        check("wait_idle_exit_busy", 32'(Rx_busy), 32'h0);
        idle(15);
        check("stop_fault_pulses", 32'(n_valid - n0), 32'd1);

        // Back-to-back frames with no idle gap.
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b1, 1'b1);
        idle(4);
        check("b2b_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'd11);

        // Reset during data bit 4 of 0xFF.
        n0 = n_valid;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b1;
        send_bit(1'b1);
        check("midrst_data", 32'(Rx_data), 32'h0);
        check("midrst_valid", 32'(Rx_valid), 32'h0);
        check("midrst_perr", 32'(Parity_error), 32'h0);
        check("midrst_ferr", 32'(Frame_error), 32'h0);
        check("midrst_busy", 32'(Rx_busy), 32'h0);
        send_bit(1'b1);
        rst = 1'b0;
        idle(3);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
        idle(4);
        check("midrst_pulses", 32'(n_valid - n0), 32'd1);

        // Loopback-style stream of 20 random words.
        n0 = n_valid;
        for (int k = 0; k < 20; k++) begin
            w = 8'($urandom);
            send_frame(w, 1'b1, 1'b1, 1'b1);
            if (k % 4 == 3) idle(1 + (k % 3));
        end
        idle(6);
        check("loopback_pulses", 32'(n_valid - n0), 32'd20);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
